// File: rtl/dot11_tx_data_framer.sv
// +--------------------------------------------------------------------------+
// | Module   : dot11_tx_data_framer                                          |
// | Purpose  : Builds the legacy 802.11 DATA-field bit stream (SERVICE,      |
// |            PSDU LSB-first, optional FCS, tail, pad), scrambled with      |
// |            x^7+x^4+1, and reports the OFDM symbol count on completion.   |
// | Options  : OPENOFDM_TX_FCS_INSERT_EN - compute and append CRC-32 FCS.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module dot11_tx_data_framer #(
    parameter int LEN_WIDTH  = 16,
    parameter int NSYM_WIDTH = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [3:0]            pkt_rate,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic [6:0]            scrambler_seed,
    input  logic [7:0]            byte_in,
    input  logic                  byte_in_valid,
    output logic                  byte_in_ready,
    output logic                  bit_out,
    output logic                  bit_out_valid,
    input  logic                  bit_out_ready,
    output logic                  bit_out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  len_error,
    output logic [NSYM_WIDTH-1:0] n_ofdm_sym
);

    localparam logic [2:0]  c_ST_IDLE    = 3'd0;
    localparam logic [2:0]  c_ST_SERVICE = 3'd1;
    localparam logic [2:0]  c_ST_DATA    = 3'd2;
`ifdef OPENOFDM_TX_FCS_INSERT_EN
    localparam logic [2:0]  c_ST_FCS     = 3'd3;
    localparam logic [31:0] c_CRC_POLY   = 32'hEDB88320;
`endif
    localparam logic [2:0]  c_ST_TAIL    = 3'd4;
    localparam logic [2:0]  c_ST_PAD     = 3'd5;

    logic [2:0]            r_state;
    logic [2:0]            w_state_next;
    logic [7:0]            r_ndbps;
    logic [7:0]            w_rate_ndbps;
    logic                  w_rate_ok;
    logic                  w_len_ok;
    logic                  w_accept;
    logic [LEN_WIDTH-1:0]  w_payload_len;
    logic [LEN_WIDTH-1:0]  r_fetch_left;
    logic [6:0]            r_scr;
    logic [5:0]            r_bit_idx;
    logic [7:0]            r_sym_bit;
    logic [NSYM_WIDTH-1:0] r_nsym;
    logic [7:0]            r_shift;
    logic [3:0]            r_shift_cnt;
    logic                  r_done;
    logic                  r_len_error;
    logic                  w_xfer;
    logic                  w_byte_fire;
    logic                  w_fb;
    logic                  w_wrap;
    logic                  w_raw_bit;
    logic                  w_end_cond;
`ifdef OPENOFDM_TX_FCS_INSERT_EN
    logic [31:0]           r_crc;
    logic                  w_crc_mix;
`endif

    // Map the SIGNAL rate code to data bits per OFDM symbol
    always_comb begin
        w_rate_ok    = 1'b1;
        w_rate_ndbps = 8'd0;
        case (pkt_rate)
            4'b1011: w_rate_ndbps = 8'd24;
            4'b1111: w_rate_ndbps = 8'd36;
            4'b1010: w_rate_ndbps = 8'd48;
            4'b1110: w_rate_ndbps = 8'd72;
            4'b1001: w_rate_ndbps = 8'd96;
            4'b1101: w_rate_ndbps = 8'd144;
            4'b1000: w_rate_ndbps = 8'd192;
            4'b1100: w_rate_ndbps = 8'd216;
            default: w_rate_ok    = 1'b0;
        endcase
    end

`ifdef OPENOFDM_TX_FCS_INSERT_EN
    // Four of the pkt_len bytes are the FCS we generate ourselves
    assign w_len_ok      = (pkt_len >= LEN_WIDTH'(5));
    assign w_payload_len = pkt_len - LEN_WIDTH'(4);
    assign w_crc_mix     = r_crc[0] ^ r_shift[0];
`else
    assign w_len_ok      = (pkt_len != '0);
    assign w_payload_len = pkt_len;
`endif

    assign w_accept    = start && (r_state == c_ST_IDLE) && w_rate_ok && w_len_ok;
    assign w_xfer      = bit_out_valid && bit_out_ready;
    assign w_byte_fire = byte_in_valid && byte_in_ready;
    assign w_fb        = r_scr[6] ^ r_scr[3];
    assign w_wrap      = (r_sym_bit == (r_ndbps - 8'd1));
    // Current bit is the final bit of the frame if transferred now
    assign w_end_cond  = ((r_state == c_ST_TAIL) && (r_bit_idx == 6'd5) && w_wrap) ||
                         ((r_state == c_ST_PAD) && w_wrap);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: each field ends on the transfer of its last bit
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:    if (w_accept) w_state_next = c_ST_SERVICE;
            c_ST_SERVICE: if (w_xfer && (r_bit_idx == 6'd15)) w_state_next = c_ST_DATA;
            c_ST_DATA:    if (w_xfer && (r_shift_cnt == 4'd1) && (r_fetch_left == '0))
`ifdef OPENOFDM_TX_FCS_INSERT_EN
                              w_state_next = c_ST_FCS;
            c_ST_FCS:     if (w_xfer && (r_bit_idx == 6'd31)) w_state_next = c_ST_TAIL;
`else
                              w_state_next = c_ST_TAIL;
`endif
            c_ST_TAIL:    if (w_xfer && (r_bit_idx == 6'd5))
                              w_state_next = w_wrap ? c_ST_IDLE : c_ST_PAD;
            c_ST_PAD:     if (w_xfer && w_wrap) w_state_next = c_ST_IDLE;
            default:      w_state_next = c_ST_IDLE;
        endcase
    end

    // Outputs: bit source per state and byte-fetch handshake
    always_comb begin
        bit_out_valid = 1'b0;
        w_raw_bit     = 1'b0;
        byte_in_ready = 1'b0;
        case (r_state)
            c_ST_SERVICE: begin
                bit_out_valid = 1'b1;
                byte_in_ready = (r_bit_idx == 6'd15) && (r_shift_cnt == 4'd0) &&
                                (r_fetch_left != '0);
            end
            c_ST_DATA: begin
                bit_out_valid = (r_shift_cnt != 4'd0);
                w_raw_bit     = r_shift[0];
                // Refill while the byte's last bit leaves, so no bubble appears
                byte_in_ready = (r_fetch_left != '0) &&
                                ((r_shift_cnt == 4'd0) ||
                                 ((r_shift_cnt == 4'd1) && bit_out_ready));
            end
`ifdef OPENOFDM_TX_FCS_INSERT_EN
            c_ST_FCS: begin
                bit_out_valid = 1'b1;
                w_raw_bit     = ~r_crc[0];
            end
`endif
            c_ST_TAIL, c_ST_PAD: bit_out_valid = 1'b1;
            default: ;
        endcase
    end

    // Tail bits leave unscrambled as zeros; everything else is scrambled
    assign bit_out      = bit_out_valid && (r_state != c_ST_TAIL) && (w_raw_bit ^ w_fb);
    assign bit_out_last = bit_out_valid && w_end_cond;
    assign busy         = (r_state != c_ST_IDLE);
    assign done         = r_done;
    assign len_error    = r_len_error;
    assign n_ofdm_sym   = r_nsym;

    // Datapath: scrambler, bit/symbol counters, byte shift register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ndbps      <= 8'd0;
            r_fetch_left <= '0;
            r_scr        <= 7'd0;
            r_bit_idx    <= 6'd0;
            r_sym_bit    <= 8'd0;
            r_nsym       <= '0;
            r_shift      <= 8'd0;
            r_shift_cnt  <= 4'd0;
            r_done       <= 1'b0;
            r_len_error  <= 1'b0;
        end else begin
            r_done      <= w_xfer && w_end_cond;
            r_len_error <= start && (r_state == c_ST_IDLE) && !(w_rate_ok && w_len_ok);
            if (w_accept) begin
                r_ndbps      <= w_rate_ndbps;
                r_fetch_left <= w_payload_len;
                r_scr        <= (scrambler_seed == 7'd0) ? 7'h7F : scrambler_seed;
                r_bit_idx    <= 6'd0;
                r_sym_bit    <= 8'd0;
                r_nsym       <= '0;
                r_shift      <= 8'd0;
                r_shift_cnt  <= 4'd0;
            end
            if (w_xfer) begin
                r_scr     <= {r_scr[5:0], w_fb};
                r_bit_idx <= (w_state_next != r_state) ? 6'd0 : r_bit_idx + 6'd1;
                if (w_wrap) begin
                    r_sym_bit <= 8'd0;
                    r_nsym    <= r_nsym + NSYM_WIDTH'(1);
                end else begin
                    r_sym_bit <= r_sym_bit + 8'd1;
                end
                if (r_state == c_ST_DATA) begin
                    r_shift     <= {1'b0, r_shift[7:1]};
                    r_shift_cnt <= r_shift_cnt - 4'd1;
                end
            end
            // A fresh byte overrides the drain of the previous one
            if (w_byte_fire) begin
                r_shift      <= byte_in;
                r_shift_cnt  <= 4'd8;
                r_fetch_left <= r_fetch_left - LEN_WIDTH'(1);
            end
        end
    end

`ifdef OPENOFDM_TX_FCS_INSERT_EN
    // Reflected CRC-32 over payload bits, then shifted out as the FCS
    always_ff @(posedge clock) begin
        if (reset) begin
            r_crc <= 32'd0;
        end else if (w_accept) begin
            r_crc <= 32'hFFFFFFFF;
        end else if (w_xfer && (r_state == c_ST_DATA)) begin
            r_crc <= {1'b0, r_crc[31:1]} ^ (w_crc_mix ? c_CRC_POLY : 32'd0);
        end else if (w_xfer && (r_state == c_ST_FCS)) begin
            r_crc <= {1'b0, r_crc[31:1]};
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dot11_tx_data_framer.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_dot11_tx_data_framer                                       |
// | Purpose  : Self-checking bench for dot11_tx_data_framer against a        |
// |            queue-based model of the DATA-field construction rules.       |
// | Options  : follows OPENOFDM_TX_FCS_INSERT_EN like the design.            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_dot11_tx_data_framer;

    localparam int LEN_WIDTH  = 16;
    localparam int NSYM_WIDTH = 15;
`ifdef OPENOFDM_TX_FCS_INSERT_EN
    localparam int c_FCS_ON = 1;
`else
    localparam int c_FCS_ON = 0;
`endif
    localparam logic [3:0] c_RATES [8] = '{4'b1011, 4'b1111, 4'b1010, 4'b1110,
                                           4'b1001, 4'b1101, 4'b1000, 4'b1100};

    logic                  clock;
    logic                  reset;
    logic                  start;
    logic [3:0]            pkt_rate;
    logic [LEN_WIDTH-1:0]  pkt_len;
    logic [6:0]            scrambler_seed;
    logic [7:0]            byte_in;
    logic                  byte_in_valid;
    logic                  byte_in_ready;
    logic                  bit_out;
    logic                  bit_out_valid;
    logic                  bit_out_ready;
    logic                  bit_out_last;
    logic                  busy;
    logic                  done;
    logic                  len_error;
    logic [NSYM_WIDTH-1:0] n_ofdm_sym;

    dot11_tx_data_framer #(
        .LEN_WIDTH  (LEN_WIDTH),
        .NSYM_WIDTH (NSYM_WIDTH)
    ) u_dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .pkt_rate       (pkt_rate),
        .pkt_len        (pkt_len),
        .scrambler_seed (scrambler_seed),
        .byte_in        (byte_in),
        .byte_in_valid  (byte_in_valid),
        .byte_in_ready  (byte_in_ready),
        .bit_out        (bit_out),
        .bit_out_valid  (bit_out_valid),
        .bit_out_ready  (bit_out_ready),
        .bit_out_last   (bit_out_last),
        .busy           (busy),
        .done           (done),
        .len_error      (len_error),
        .n_ofdm_sym     (n_ofdm_sym)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         n_checks;
    int         n_errors;
    logic [7:0] pay [$];
    bit         got_q [$];
    bit         exp_q [$];
    bit         ks_q [$];
    bit         ref_q [$];
    int         got_last_idx;
    int         got_last_cnt;
    int         done_cnt;
    int         stable_err;
    int         feed_idx;
    int         busy_at_done;
    int         nsym_got;
    bit         frame_finished;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int ndbps_of(input logic [3:0] rate);
        case (rate)
            4'b1011: return 24;
            4'b1111: return 36;
            4'b1010: return 48;
            4'b1110: return 72;
            4'b1001: return 96;
            4'b1101: return 144;
            4'b1000: return 192;
            4'b1100: return 216;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] crc32_pay(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, pay[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Expected frame: field list -> padded to whole symbols -> scrambled
    task automatic build_model(input logic [3:0] rate, input logic [6:0] seed);
        bit          u [$];
        int          nd;
        int          tail_at;
        int          nsym;
        logic [31:0] crc;
        logic [7:0]  t;
        logic [6:0]  s;
        bit          fb;
        nd = ndbps_of(rate);
        exp_q.delete();
        ks_q.delete();
        for (int i = 0; i < 16; i++) u.push_back(1'b0);
        for (int i = 0; i < pay.size(); i++) begin
            t = pay[i];
            for (int b = 0; b < 8; b++) u.push_back(t[b]);
        end
        if (c_FCS_ON != 0) begin
            crc = crc32_pay(pay.size());
            for (int b = 0; b < 32; b++) u.push_back(crc[b]);
        end
        tail_at = u.size();
        for (int i = 0; i < 6; i++) u.push_back(1'b0);
        nsym = (u.size() + nd - 1) / nd;
        while (u.size() < nsym * nd) u.push_back(1'b0);
        s = (seed == 7'd0) ? 7'h7F : seed;
        for (int i = 0; i < u.size(); i++) begin
            fb = s[6] ^ s[3];
            ks_q.push_back(fb);
            exp_q.push_back((i >= tail_at && i < tail_at + 6) ? 1'b0 : (u[i] ^ fb));
            s = {s[5:0], fb};
        end
    endtask

    task automatic fill_random(input int len);
        pay.delete();
        for (int i = 0; i < len - 4 * c_FCS_ON; i++) pay.push_back(8'($urandom));
    endtask

    task automatic fill_vector();
        logic [31:0] crc;
        pay.delete();
        for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
        if (c_FCS_ON == 0) begin
            crc = crc32_pay(9);
            for (int k = 0; k < 4; k++) pay.push_back(crc[8*k +: 8]);
        end
    endtask

    // mode: 0 ready always, 1 ready toggling, 2 random ready and byte gaps
    task automatic run_frame(input logic [3:0] rate, input int len, input logic [6:0] seed,
                             input int mode, input int stall_at, input int abort_at,
                             input int dup_at);
        int cyc;
        int stall_left;
        bit prev_hold;
        bit prev_bit;
        got_q.delete();
        got_last_idx   = -1;
        got_last_cnt   = 0;
        done_cnt       = 0;
        stable_err     = 0;
        feed_idx       = 0;
        busy_at_done   = 1;
        nsym_got       = -1;
        frame_finished = 0;
        stall_left     = 20;
        prev_hold      = 0;
        prev_bit       = 0;
        @(posedge clock); #1;
        start = 1'b1; pkt_rate = rate; pkt_len = LEN_WIDTH'(len); scrambler_seed = seed;
        @(posedge clock); #1;
        start = 1'b0;
        cyc   = 0;
        while (!frame_finished && cyc < 20000) begin
            if (mode == 0)      bit_out_ready = 1'b1;
            else if (mode == 1) bit_out_ready = (cyc % 2 == 0);
            else                bit_out_ready = ($urandom_range(0, 3) != 0);
            byte_in_valid = 1'b0;
            byte_in       = 8'h00;
            if (feed_idx < pay.size()) begin
                if (stall_at >= 0 && feed_idx == stall_at && stall_left > 0) begin
                    stall_left--;
                end else if (!(mode == 2 && $urandom_range(0, 4) == 0)) begin
                    byte_in_valid = 1'b1;
                    byte_in       = pay[feed_idx];
                end
            end
            start = (cyc == dup_at);
            if (start) begin
                pkt_rate = 4'b1000; pkt_len = LEN_WIDTH'(7); scrambler_seed = 7'h11;
            end
            @(negedge clock);
            if (prev_hold && (!bit_out_valid || bit_out !== prev_bit)) stable_err++;
            prev_hold = bit_out_valid && !bit_out_ready;
            prev_bit  = bit_out;
            if (byte_in_valid && byte_in_ready) feed_idx++;
            if (bit_out_valid && bit_out_ready) begin
                if (bit_out_last) begin
                    got_last_idx = got_q.size();
                    got_last_cnt++;
                end
                got_q.push_back(bit_out);
            end
            if (done) begin
                done_cnt++;
                busy_at_done   = busy;
                nsym_got       = n_ofdm_sym;
                frame_finished = 1;
            end
            if (abort_at >= 0 && got_q.size() == abort_at) begin
                @(posedge clock); #1;
                reset = 1'b1; start = 1'b0; byte_in_valid = 1'b0;
                @(posedge clock); #1;
                reset = 1'b0;
                return;
            end
            @(posedge clock); #1;
            cyc++;
        end
        start         = 1'b0;
        byte_in_valid = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (done) done_cnt++;
        end
    endtask

    function automatic int diff_exp();
        int d = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) if (got_q[i] != exp_q[i]) d++;
        return d;
    endfunction

    function automatic int diff_ref();
        int d = 0;
        for (int i = 0; i < ref_q.size() && i < got_q.size(); i++) if (got_q[i] != ref_q[i]) d++;
        return d + ((ref_q.size() == got_q.size()) ? 0 : 1);
    endfunction

    task automatic check_frame(input string tag, input logic [3:0] rate, input int len);
        int nd;
        nd = ndbps_of(rate);
        chk({tag, "_finished"}, 32'(frame_finished), 32'd1);
        chk({tag, "_nbits"},    32'(got_q.size()),   32'(exp_q.size()));
        chk({tag, "_bitdiff"},  32'(diff_exp()),     32'd0);
        chk({tag, "_last_idx"}, 32'(got_last_idx),   32'(exp_q.size() - 1));
        chk({tag, "_last_cnt"}, 32'(got_last_cnt),   32'd1);
        chk({tag, "_done_cnt"}, 32'(done_cnt),       32'd1);
        chk({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
        chk({tag, "_nsym"},     32'(nsym_got),       32'((22 + 8 * len + nd - 1) / nd));
        chk({tag, "_bytes"},    32'(feed_idx),       32'(pay.size()));
        chk({tag, "_stable"},   32'(stable_err),     32'd0);
    endtask

    task automatic try_reject(input string tag, input logic [3:0] rate, input int len);
        int errs;
        int busy_seen;
        int rdy_seen;
        errs = 0; busy_seen = 0; rdy_seen = 0;
        byte_in_valid = 1'b1; byte_in = 8'hA5; bit_out_ready = 1'b1;
        @(posedge clock); #1;
        start = 1'b1; pkt_rate = rate; pkt_len = LEN_WIDTH'(len); scrambler_seed = 7'h55;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (len_error)     errs++;
            if (busy)          busy_seen++;
            if (byte_in_ready) rdy_seen++;
        end
        byte_in_valid = 1'b0;
        chk({tag, "_len_error"}, 32'(errs),      32'd1);
        chk({tag, "_busy"},      32'(busy_seen), 32'd0);
        chk({tag, "_ready"},     32'(rdy_seen),  32'd0);
    endtask

    // Main sequence
    initial begin
        logic [15:0] first16;
        logic [7:0]  v;
        logic [7:0]  fcs_exp [4];
        logic [3:0]  rate;
        int          len;
        logic [6:0]  seed;
        fcs_exp  = '{8'h26, 8'h39, 8'hF4, 8'hCB};
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1; start = 1'b0; pkt_rate = 4'd0; pkt_len = '0; scrambler_seed = 7'd0;
        byte_in = 8'd0; byte_in_valid = 1'b0; bit_out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        chk("rst_busy",  32'(busy),          32'd0);
        chk("rst_done",  32'(done),          32'd0);
        chk("rst_lerr",  32'(len_error),     32'd0);
        chk("rst_valid", 32'(bit_out_valid), 32'd0);
        chk("rst_bit",   32'(bit_out),       32'd0);
        chk("rst_last",  32'(bit_out_last),  32'd0);
        chk("rst_ready", 32'(byte_in_ready), 32'd0);
        chk("rst_nsym",  32'(n_ofdm_sym),    32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Reference vector: "123456789", FCS CBF43926
        fill_vector();
        build_model(4'b1011, 7'h7F);
        run_frame(4'b1011, 13, 7'h7F, 0, -1, -1, -1);
        check_frame("vec", 4'b1011, 13);
        for (int i = 0; i < 16; i++) first16[15-i] = got_q[i];
        chk("vec_service", 32'(first16), 32'h0EF2);
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 8; b++) v[b] = got_q[88 + 8*k + b] ^ ks_q[88 + 8*k + b];
            chk($sformatf("vec_fcs%0d", k), 32'(v), 32'(fcs_exp[k]));
        end
        chk("vec_total", 32'(got_q.size()), 32'd144);
        chk("vec_pad",   32'(got_q.size() - 126), 32'd18);
        ref_q = got_q;

        // Same frame with ready toggling and a 20-cycle byte starvation
        run_frame(4'b1011, 13, 7'h7F, 1, 4, -1, -1);
        check_frame("tog", 4'b1011, 13);
        chk("tog_vs_ref", 32'(diff_ref()), 32'd0);

        // Seed 0 behaves as seed 7F
        build_model(4'b1011, 7'h00);
        run_frame(4'b1011, 13, 7'h00, 0, -1, -1, -1);
        check_frame("seed0", 4'b1011, 13);
        chk("seed0_vs_ref", 32'(diff_ref()), 32'd0);

        // Long frame at the highest rate
        fill_random(1000);
        build_model(4'b1100, 7'h2B);
        run_frame(4'b1100, 1000, 7'h2B, 0, -1, -1, -1);
        check_frame("long", 4'b1100, 1000);
        chk("long_nsym38", 32'(nsym_got),     32'd38);
        chk("long_last",   32'(got_last_idx), 32'd8207);

        // Rejected starts
        try_reject("rej_rate", 4'b0000, 13);
        try_reject("rej_len0", 4'b1011, 0);
        if (c_FCS_ON != 0) try_reject("rej_len3", 4'b1011, 3);
        else               try_reject("rej_rate7", 4'b0111, 20);

        // Reset at bit 50, then a fresh frame with an ignored second start
        fill_random(40);
        run_frame(4'b1101, 40, 7'h5A, 2, -1, 50, -1);
        @(negedge clock);
        chk("abort_busy",  32'(busy),          32'd0);
        chk("abort_valid", 32'(bit_out_valid), 32'd0);
        chk("abort_ready", 32'(byte_in_ready), 32'd0);
        chk("abort_nsym",  32'(n_ofdm_sym),    32'd0);
        fill_random(30);
        build_model(4'b1001, 7'h33);
        run_frame(4'b1001, 30, 7'h33, 2, -1, -1, 30);
        check_frame("after_abort", 4'b1001, 30);

        // Random frames
        for (int k = 0; k < 6; k++) begin
            rate = c_RATES[$urandom_range(0, 7)];
            len  = $urandom_range((c_FCS_ON != 0) ? 5 : 1, 48);
            seed = 7'($urandom);
            fill_random(len);
            build_model(rate, seed);
            run_frame(rate, len, seed, 2, -1, -1, -1);
            check_frame($sformatf("rnd%0d", k), rate, len);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
